// File: rtl/mem_access.sv
// MEM-stage data-bus controller: issues loads/stores on an SRAM-like req/addr_ok/data_ok bus,
// flags misaligned accesses, extends load data and stalls the pipeline until the access retires.
module mem_access #(
    parameter bit BUF_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        ex_ren_i,
    input  logic        ex_wen_i,
    input  logic [2:0]  ex_mem_type_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_has_exc_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] mem_r_data_o,
    output logic        mem_adel_o,
    output logic        mem_ades_o,
    output logic        mem_stall_req
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_BU = 3'b001;
    localparam logic [2:0] MT_H  = 3'b010;
    localparam logic [2:0] MT_HU = 3'b011;

    function automatic logic is_misaligned(input logic [2:0] mt, input logic [1:0] off);
        logic mis;
        case (mt)
            MT_H, MT_HU: mis = off[0];
            MT_B, MT_BU: mis = 1'b0;
            default:     mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] size_of(input logic [1:0] mt_hi);
        logic [1:0] sz;
        case (mt_hi)
            2'b00:   sz = 2'd0;
            2'b01:   sz = 2'd1;
            default: sz = 2'd2;
        endcase
        return sz;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] lanes;
        case (sz)
            2'd0:    lanes = {4{wd[7:0]}};
            2'd1:    lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_extend(input logic [2:0] mt, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (mt)
            MT_B:    res = {{24{b[7]}}, b};
            MT_BU:   res = {24'h000000, b};
            MT_H:    res = {{16{h[15]}}, h};
            MT_HU:   res = {16'h0000, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic        abort_q, abort_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  type_q, type_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;

    logic        mis_s;
    logic        go_s;
    logic        abort_s;
    logic [1:0]  ex_size_s;
    logic [31:0] ex_lanes_s;
    logic [31:0] ld_ext_s;

    assign mis_s      = is_misaligned(ex_mem_type_i, ex_addr_i[1:0]);
    assign mem_adel_o = ex_ren_i & mis_s;
    assign mem_ades_o = ex_wen_i & mis_s;
    assign go_s       = (ex_ren_i | ex_wen_i) & ~mis_s & ~ex_has_exc_i & ~flush;
    assign abort_s    = abort_q | flush;
    assign ex_size_s  = size_of(ex_mem_type_i[2:1]);
    assign ex_lanes_s = store_lanes(ex_size_s, ex_wdata_i);
    assign ld_ext_s   = load_extend(type_q, addr_q[1:0], data_rdata);

    // Next-state, abort tracking, request capture and load buffer update.
    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        size_d  = size_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (go_s) begin
                    addr_d  = ex_addr_i;
                    wdata_d = ex_lanes_s;
                    type_d  = ex_mem_type_i;
                    size_d  = ex_size_s;
                    wr_d    = ex_wen_i;
                    state_d = data_addr_ok ? S_WAIT : S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (flush) begin
                    abort_d = 1'b1;
                end else begin
                    abort_d = abort_q;
                end
                if (data_addr_ok) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    if (abort_s) begin
                        // Aborted access: the returning data is dropped, buffer untouched.
                        abort_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        if (!wr_q) begin
                            buf_d = ld_ext_s;
                        end else begin
                            buf_d = buf_q;
                        end
                        if (!BUF_BYPASS || stall) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    abort_d = abort_s;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (flush || !stall) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus drive, stall request and load result; the bus is fed from the captured request once issued.
    always_comb begin
        data_req      = 1'b0;
        data_wr       = wr_q;
        data_size     = size_q;
        data_addr     = addr_q;
        data_wdata    = wdata_q;
        mem_stall_req = 1'b0;
        mem_r_data_o  = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (go_s) begin
                    data_req      = 1'b1;
                    data_wr       = ex_wen_i;
                    data_size     = ex_size_s;
                    data_addr     = ex_addr_i;
                    data_wdata    = ex_lanes_s;
                    mem_stall_req = 1'b1;
                end else begin
                    mem_stall_req = 1'b0;
                end
            end
            S_REQ: begin
                data_req      = 1'b1;
                mem_stall_req = abort_s ? go_s : 1'b1;
            end
            S_WAIT: begin
                if (abort_s) begin
                    // Hold any younger memory op until the orphaned access drains.
                    mem_stall_req = go_s;
                end else if (data_data_ok) begin
                    mem_stall_req = ~BUF_BYPASS;
                    if (BUF_BYPASS && !wr_q) begin
                        mem_r_data_o = ld_ext_s;
                    end else begin
                        mem_r_data_o = 32'h0000_0000;
                    end
                end else begin
                    mem_stall_req = 1'b1;
                end
            end
            S_DONE: begin
                mem_stall_req = 1'b0;
                mem_r_data_o  = wr_q ? 32'h0000_0000 : buf_q;
            end
            default: begin
                mem_stall_req = 1'b0;
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            abort_q <= 1'b0;
            buf_q   <= 32'h0000_0000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            type_q  <= 3'b000;
            size_q  <= 2'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table of single accesses plus hand-built
// sequences for slow handshakes, flush/abort, external stall and reset.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst, flush, stall, ex_ren_i, ex_wen_i, ex_has_exc_i;
    logic [2:0]  ex_mem_type_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, mem_r_data_o;
    logic        mem_adel_o, mem_ades_o, mem_stall_req;

    always #5 clk = ~clk;

    mem_access #(.BUF_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .ex_ren_i(ex_ren_i), .ex_wen_i(ex_wen_i), .ex_mem_type_i(ex_mem_type_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_has_exc_i(ex_has_exc_i),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_r_data_o(mem_r_data_o), .mem_adel_o(mem_adel_o), .mem_ades_o(mem_ades_o),
        .mem_stall_req(mem_stall_req)
    );

    typedef struct {
        string       name;
        logic [2:0]  mt;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_r;
        logic [31:0] exp_wd;
        logic [1:0]  exp_sz;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    function automatic vec_t mk(input string nm, input logic [2:0] mt, input logic ren,
                                input logic wen, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic [31:0] er,
                                input logic [31:0] ewd, input logic [1:0] sz,
                                input logic adel, input logic ades);
        vec_t v;
        v.name = nm; v.mt = mt; v.ren = ren; v.wen = wen; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.exp_r = er; v.exp_wd = ewd; v.exp_sz = sz;
        v.exp_adel = adel; v.exp_ades = ades;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic sb_check(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: got 0x%08h, expected nothing (scoreboard empty)", name, mem_r_data_o);
        end else begin
            e = exp_q.pop_front();
            chk32(name, mem_r_data_o, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_ex(input logic ren, input logic wen, input logic [2:0] mt,
                          input logic [31:0] a, input logic [31:0] wd);
        ex_ren_i = ren; ex_wen_i = wen; ex_mem_type_i = mt; ex_addr_i = a; ex_wdata_i = wd;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000);
    endtask

    initial begin
        vecs[0]  = mk("lw_100",   3'b100, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 2'd2, 1'b0, 1'b0);
        vecs[1]  = mk("lb_103",   3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80112233, 32'hFFFFFF80, 32'h0, 2'd0, 1'b0, 1'b0);
        vecs[2]  = mk("lbu_103",  3'b001, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80112233, 32'h00000080, 32'h0, 2'd0, 1'b0, 1'b0);
        vecs[3]  = mk("lhu_102",  3'b011, 1'b1, 1'b0, 32'h102, 32'h0, 32'h80112233, 32'h00008011, 32'h0, 2'd1, 1'b0, 1'b0);
        vecs[4]  = mk("lh_102",   3'b010, 1'b1, 1'b0, 32'h102, 32'h0, 32'h80112233, 32'hFFFF8011, 32'h0, 2'd1, 1'b0, 1'b0);
        vecs[5]  = mk("lh_100",   3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h80112233, 32'h00002233, 32'h0, 2'd1, 1'b0, 1'b0);
        vecs[6]  = mk("lb_101",   3'b000, 1'b1, 1'b0, 32'h101, 32'h0, 32'h80112233, 32'h00000022, 32'h0, 2'd0, 1'b0, 1'b0);
        vecs[7]  = mk("lbu_102",  3'b001, 1'b1, 1'b0, 32'h102, 32'h0, 32'h80F12233, 32'h000000F1, 32'h0, 2'd0, 1'b0, 1'b0);
        vecs[8]  = mk("sh_106",   3'b010, 1'b0, 1'b1, 32'h106, 32'h1234ABCD, 32'h0, 32'h0, 32'hABCDABCD, 2'd1, 1'b0, 1'b0);
        vecs[9]  = mk("sb_101",   3'b000, 1'b0, 1'b1, 32'h101, 32'h000000A5, 32'h0, 32'h0, 32'hA5A5A5A5, 2'd0, 1'b0, 1'b0);
        vecs[10] = mk("sw_108",   3'b100, 1'b0, 1'b1, 32'h108, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0);
        vecs[11] = mk("lh_101",   3'b010, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b1, 1'b0);
        vecs[12] = mk("sw_102",   3'b100, 1'b0, 1'b1, 32'h102, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
        vecs[13] = mk("lw_103",   3'b100, 1'b1, 1'b0, 32'h103, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b1, 1'b0);

        rst = 1'b1; flush = 1'b0; stall = 1'b0; ex_has_exc_i = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        idle_ex();
        repeat (3) cyc();
        rst = 1'b0;
        smp();
        chk1("reset_req", data_req, 1'b0);
        chk1("reset_stall", mem_stall_req, 1'b0);
        chk32("reset_rdata", mem_r_data_o, 32'h0);

        // Table: each access gets addr_ok at once and data_ok two cycles later.
        for (int i = 0; i < 14; i++) begin
            cyc();
            set_ex(vecs[i].ren, vecs[i].wen, vecs[i].mt, vecs[i].addr, vecs[i].wdata);
            data_addr_ok = 1'b1; data_data_ok = 1'b0;
            smp();
            chk1({vecs[i].name, "_adel"}, mem_adel_o, vecs[i].exp_adel);
            chk1({vecs[i].name, "_ades"}, mem_ades_o, vecs[i].exp_ades);
            if (vecs[i].exp_adel || vecs[i].exp_ades) begin
                chk1({vecs[i].name, "_noreq"}, data_req, 1'b0);
                chk1({vecs[i].name, "_nostall"}, mem_stall_req, 1'b0);
                cyc(); idle_ex(); data_addr_ok = 1'b0;
                smp();
                chk1({vecs[i].name, "_noreq2"}, data_req, 1'b0);
            end else begin
                chk1({vecs[i].name, "_req"}, data_req, 1'b1);
                chk1({vecs[i].name, "_wr"}, data_wr, vecs[i].wen);
                chk32({vecs[i].name, "_size"}, {30'd0, data_size}, {30'd0, vecs[i].exp_sz});
                chk32({vecs[i].name, "_addr"}, data_addr, vecs[i].addr);
                chk1({vecs[i].name, "_stall0"}, mem_stall_req, 1'b1);
                if (vecs[i].wen) chk32({vecs[i].name, "_wdata"}, data_wdata, vecs[i].exp_wd);
                exp_q.push_back(vecs[i].exp_r);
                cyc(); data_addr_ok = 1'b0;
                smp();
                chk1({vecs[i].name, "_wait_req"}, data_req, 1'b0);
                chk1({vecs[i].name, "_stall1"}, mem_stall_req, 1'b1);
                cyc(); data_data_ok = 1'b1; data_rdata = vecs[i].rdata;
                smp();
                chk1({vecs[i].name, "_stall_ok"}, mem_stall_req, 1'b0);
                sb_check({vecs[i].name, "_result"});
                cyc(); data_data_ok = 1'b0; idle_ex();
                smp();
                chk1({vecs[i].name, "_idle_req"}, data_req, 1'b0);
                chk32({vecs[i].name, "_idle_rdata"}, mem_r_data_o, 32'h0);
            end
        end

        // addr_ok delayed three cycles: request must stay up and unchanged.
        cyc(); set_ex(1'b1, 1'b0, 3'b100, 32'h200, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc();
            data_addr_ok = (k == 3);
            smp();
            chk1("slow_req", data_req, 1'b1);
            chk32("slow_addr", data_addr, 32'h200);
            chk1("slow_stall", mem_stall_req, 1'b1);
        end
        exp_q.push_back(32'h11223344);
        cyc(); data_addr_ok = 1'b0;
        smp();
        chk1("slow_wait_stall", mem_stall_req, 1'b1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'h11223344;
        smp();
        sb_check("slow_result");
        cyc(); data_data_ok = 1'b0; idle_ex();

        // Flush in WAIT: stale data discarded, younger load waits for the drain.
        cyc(); set_ex(1'b1, 1'b0, 3'b100, 32'h300, 32'h0); data_addr_ok = 1'b1;
        smp();
        chk1("fl_issue", data_req, 1'b1);
        cyc(); data_addr_ok = 1'b0; flush = 1'b1; idle_ex();
        smp();
        chk1("fl_stall", mem_stall_req, 1'b0);
        cyc(); flush = 1'b0; set_ex(1'b1, 1'b0, 3'b100, 32'h304, 32'h0);
        smp();
        chk1("fl_hold_req", data_req, 1'b0);
        chk1("fl_hold_stall", mem_stall_req, 1'b1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'h00000055;
        smp();
        chk32("fl_discard", mem_r_data_o, 32'h0);
        chk1("fl_discard_req", data_req, 1'b0);
        chk1("fl_discard_stall", mem_stall_req, 1'b1);
        cyc(); data_data_ok = 1'b0; data_addr_ok = 1'b1;
        smp();
        chk1("fl_next_req", data_req, 1'b1);
        chk32("fl_next_addr", data_addr, 32'h304);
        exp_q.push_back(32'h00000066);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h00000066;
        smp();
        sb_check("fl_next_result");
        cyc(); data_data_ok = 1'b0; idle_ex();

        // External stall during data_ok: result served from the buffer in DONE.
        cyc(); set_ex(1'b1, 1'b0, 3'b100, 32'h400, 32'h0); data_addr_ok = 1'b1;
        smp();
        exp_q.push_back(32'hA5A50F0F);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; stall = 1'b1; data_rdata = 32'hA5A50F0F;
        smp();
        chk1("st_ok_stall", mem_stall_req, 1'b0);
        sb_check("st_bypass");
        cyc(); data_data_ok = 1'b0;
        smp();
        chk1("st_done_req", data_req, 1'b0);
        chk1("st_done_stall", mem_stall_req, 1'b0);
        chk32("st_done_buf", mem_r_data_o, 32'hA5A50F0F);
        cyc(); stall = 1'b0;
        smp();
        chk32("st_done_buf2", mem_r_data_o, 32'hA5A50F0F);
        cyc(); idle_ex();
        smp();
        chk32("st_after", mem_r_data_o, 32'h0);

        // flush together with data_ok: data dropped, next load issues at once.
        cyc(); set_ex(1'b1, 1'b0, 3'b100, 32'h500, 32'h0); data_addr_ok = 1'b1;
        smp();
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; flush = 1'b1; data_rdata = 32'h77;
        smp();
        chk32("fd_discard", mem_r_data_o, 32'h0);
        chk1("fd_stall", mem_stall_req, 1'b0);
        cyc(); flush = 1'b0; data_data_ok = 1'b0; data_addr_ok = 1'b1;
        set_ex(1'b1, 1'b0, 3'b100, 32'h504, 32'h0);
        smp();
        chk1("fd_next_req", data_req, 1'b1);
        chk32("fd_next_addr", data_addr, 32'h504);
        exp_q.push_back(32'h88);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h88;
        smp();
        sb_check("fd_next_result");
        cyc(); data_data_ok = 1'b0; idle_ex();

        // Earlier-stage exception suppresses the access.
        cyc(); set_ex(1'b1, 1'b0, 3'b100, 32'h600, 32'h0); ex_has_exc_i = 1'b1; data_addr_ok = 1'b1;
        smp();
        chk1("exc_req", data_req, 1'b0);
        chk1("exc_stall", mem_stall_req, 1'b0);
        chk1("exc_adel", mem_adel_o, 1'b0);
        cyc(); ex_has_exc_i = 1'b0; idle_ex(); data_addr_ok = 1'b0;

        // Reset while a request is pending returns to IDLE.
        cyc(); set_ex(1'b1, 1'b0, 3'b100, 32'h700, 32'h0);
        smp();
        chk1("rst_pre_req", data_req, 1'b1);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; idle_ex();
        smp();
        chk1("rst_mid_req", data_req, 1'b0);
        chk1("rst_mid_stall", mem_stall_req, 1'b0);
        cyc(); set_ex(1'b1, 1'b0, 3'b100, 32'h704, 32'h0); data_addr_ok = 1'b1;
        smp();
        chk1("rst_next_req", data_req, 1'b1);
        chk32("rst_next_addr", data_addr, 32'h704);
        exp_q.push_back(32'h99);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h99;
        smp();
        sb_check("rst_next_result");
        cyc(); data_data_ok = 1'b0; idle_ex();
        smp();

        chk32("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
